// File: rtl/testpoint_pulser_pkg.sv
// rtl/testpoint_pulser_pkg.sv - shared state encoding and default widths for testpoint_pulser
package testpoint_pulser_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/tp_edge_counter.sv
// rtl/tp_edge_counter.sv - synchronizes an external line and counts its rising edges
module tp_edge_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (sync2_q && !prev_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sig_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/testpoint_pulser.sv
// rtl/testpoint_pulser.sv - programmable single/burst/continuous pulse source for a board test line
// Optional readback (PROBE, ECHO_CNT, MISMATCH) enabled by TESTPOINT_PULSER_READBACK_EN.
module testpoint_pulser
  import testpoint_pulser_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [CNT_W-1:0]   width_i,
  input  logic [CNT_W-1:0]   period_i,
  input  logic [BURST_W-1:0] count_i,
`ifdef TESTPOINT_PULSER_READBACK_EN
  input  logic               probe_i,
  output logic [BURST_W-1:0] echo_cnt_o,
  output logic               mismatch_o,
`endif
  output logic               pulse_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [BURST_W-1:0] pulses_sent_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   width_q, width_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [BURST_W-1:0] count_q, count_d;
  logic [BURST_W-1:0] sent_q, sent_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               start_acc;
  logic [CNT_W-1:0]   low_m1;

  assign start_acc = (state_q == ST_IDLE) && start_i && !abort_i;
  // Low phase lasts max(PERIOD-WIDTH, 1) cycles; stored minus one for the down-counter.
  assign low_m1 = (period_q > width_q) ? (period_q - width_q - 1'b1) : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    period_d = period_q;
    count_d  = count_q;
    sent_d   = sent_q;
    pulse_d  = pulse_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          sent_d = '0;
          if (width_i != '0) begin
            width_d  = width_i;
            period_d = period_i;
            count_d  = count_i;
            cnt_d    = width_i - 1'b1;
            sent_d   = BURST_W'(1);
            pulse_d  = 1'b1;
            busy_d   = 1'b1;
            state_d  = ST_HIGH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (abort_i || (cnt_q == '0 && count_q != '0 && sent_q == count_q)) begin
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          pulse_d = 1'b0;
          cnt_d   = low_m1;
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          pulse_d = 1'b1;
          sent_d  = sent_q + 1'b1;
          cnt_d   = width_q - 1'b1;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        pulse_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      width_q  <= '0;
      period_q <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      period_q <= period_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      pulse_q  <= pulse_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign pulse_o       = pulse_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pulses_sent_o = sent_q;

`ifdef TESTPOINT_PULSER_READBACK_EN
  logic [BURST_W-1:0] echo_cnt;
  logic [1:0]         chk_dly_q, chk_dly_d;
  logic               mismatch_q, mismatch_d;

  tp_edge_counter #(.CNT_W(BURST_W)) u_echo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .sig_i (probe_i),
    .clr_i (start_acc),
    .cnt_o (echo_cnt)
  );

  // Compare two cycles after DONE so the last echoed edge has cleared the synchronizer.
  always_comb begin
    chk_dly_d  = start_acc ? 2'b00 : {chk_dly_q[0], done_q};
    mismatch_d = mismatch_q;
    if (start_acc) begin
      mismatch_d = 1'b0;
    end else if (chk_dly_q[1] && echo_cnt != sent_q) begin
      mismatch_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      chk_dly_q  <= 2'b00;
      mismatch_q <= 1'b0;
    end else begin
      chk_dly_q  <= chk_dly_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign echo_cnt_o = echo_cnt;
  assign mismatch_o = mismatch_q;
`endif

endmodule

// File: tb/tb_testpoint_pulser.sv
// tb/tb_testpoint_pulser.sv - randomized scoreboard bench for testpoint_pulser
module tb_testpoint_pulser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] width, period;
  logic [7:0]  count;
  logic        pulse, busy, done;
  logic [7:0]  sent;
`ifdef TESTPOINT_PULSER_READBACK_EN
  logic        probe;
  logic [7:0]  echo;
  logic        mism;
  assign probe = pulse;
`endif

  always #5 clk = ~clk;

  testpoint_pulser dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .abort_i      (abort),
    .width_i      (width),
    .period_i     (period),
    .count_i      (count),
`ifdef TESTPOINT_PULSER_READBACK_EN
    .probe_i      (probe),
    .echo_cnt_o   (echo),
    .mismatch_o   (mism),
`endif
    .pulse_o      (pulse),
    .busy_o       (busy),
    .done_o       (done),
    .pulses_sent_o(sent)
  );

  typedef struct {
    int cyc;
    int sent;
  } done_t;

  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  bit    chk_en = 1'b0;
  done_t dq[$];
  done_t dpop;
  bit    exp_pulse[int];
  bit    exp_busy[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle compares line/busy against the model map, pops DONE events.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pulse", pulse, exp_pulse.exists(cyc) ? exp_pulse[cyc] : 1'b0);
      check("busy", busy, exp_busy.exists(cyc) ? exp_busy[cyc] : 1'b0);
      if (done) begin
        if (dq.size() == 0) begin
          check("spurious_done", done, 0);
        end else begin
          dpop = dq.pop_front();
          check("done_cycle", cyc, dpop.cyc);
          check("done_sent", sent, dpop.sent);
          check("done_pulse_low", pulse, 0);
        end
      end else if (dq.size() > 0 && cyc >= dq[0].cyc) begin
        check("done_missing", done, 1);
        void'(dq.pop_front());
      end
    end
  end

  // Launch a sequence at the current negedge; ab>0 aborts ab cycles after the START edge.
  task automatic run_seq(input int w, input int p, input int n, input int ab);
    int    k, peff, tend, a, dc, sn;
    done_t e;
    width  = 16'(w);
    period = 16'(p);
    count  = 8'(n);
    start  = 1'b1;
    abort  = 1'b0;
    k      = cyc;
    peff   = w + ((p > w) ? p - w : 1);
    tend   = (n == 0) ? 32'h3fff_ffff : k + (n - 1) * peff + w + 1;
    a      = (ab >= 1 && w != 0 && k + ab < tend) ? k + ab : -1;
    if (w == 0) begin
      dc = k + 1;
      sn = 0;
    end else if (a >= 0) begin
      dc = a + 1;
      sn = ((a - k - 1) / peff + 1) % 256;
    end else begin
      dc = tend;
      sn = n % 256;
    end
    for (int c = k + 1; c < dc; c++) begin
      exp_pulse[c] = ((c - k - 1) % peff) < w;
      exp_busy[c]  = 1'b1;
    end
    e.cyc  = dc;
    e.sent = sn;
    dq.push_back(e);
    @(negedge clk);
    while (cyc < dc) begin
      abort  = (cyc == a);
      start  = ($urandom_range(0, 3) == 0);
      width  = 16'($urandom_range(0, 9));
      period = 16'($urandom_range(0, 9));
      count  = 8'($urandom_range(0, 9));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    width  = '0;
    period = '0;
    count  = '0;
    repeat (3) @(negedge clk);
    check("rst_pulse", pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent", sent, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;

    run_seq(3, 10, 1, 0);
    run_seq(2, 5, 4, 0);
    run_seq(4, 2, 2, 0);
    run_seq(0, 7, 3, 0);
    run_seq(2, 4, 0, 9);
    run_seq(1, 1, 3, 0);

    // ABORT with START in IDLE: nothing launches, no DONE.
    start = 1'b1;
    abort = 1'b1;
    width = 16'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

`ifdef TESTPOINT_PULSER_READBACK_EN
    run_seq(2, 4, 5, 0);
    repeat (4) @(negedge clk);
    check("echo_cnt", echo, 5);
    check("mismatch", mism, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      int w, p, n, ab;
      w  = $urandom_range(0, 5);
      p  = $urandom_range(0, 10);
      n  = $urandom_range(0, 4);
      ab = (n == 0) ? $urandom_range(1, 40)
                    : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0);
      run_seq(w, p, n, ab);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Reset in the middle of a continuous train.
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    width  = 16'd2;
    period = 16'd4;
    count  = 8'd0;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pulse", pulse, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sent", sent, 0);
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_done", done, 0);
    exp_pulse.delete();
    exp_busy.delete();
    dq.delete();
    chk_en = 1'b1;
    run_seq(3, 10, 1, 0);

    repeat (4) @(negedge clk);
    check("drain", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
